mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the byte-wide `mem` SPRAM wrapper.
- Port A is the ULM core. Port B is the loader/debug port.
- Each port issues big-endian accesses of 1, 2, 4 or 8 bytes. The block arbitrates round-robin and serialises each access into one-byte-per-cycle `mem` operations.
- Read bytes are reassembled into a 64-bit result.

Parameters:
- RD_LAT, 3, cycles from a byte address on mem_addr (mem_write=0) to valid mem_rdata; matches the `mem` pipeline.
- AW, 15, byte address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A access request; held until a_ack
- a_we  in  1  port A: 1=write, 0=read
- a_size  in  2  port A byte count: 0→1, 1→2, 2→4, 3→8
- a_addr  in  AW  port A start byte address
- a_wdata  in  64  port A write data, right-justified, big-endian
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  64  port A read data, zero-extended, right-justified
- b_req, b_we, b_size, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
- mem_addr  out  AW  byte address to `mem`, registered
- mem_write  out  1  byte write strobe to `mem`, registered
- mem_wdata  out  8  byte write data to `mem`, registered
- mem_rdata  in  8  byte read data from `mem`
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous:
  - State=IDLE, priority pointer=A.
  - mem_write=0, mem_addr=0, mem_wdata=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0.
- Reset mid-access:
  - The access aborts and mem_write drops immediately. No ack is issued.
  - Bytes already written stay written. Reads in flight are discarded.
- States: IDLE → ISSUE → (DRAIN, reads only) → DONE → IDLE.
- IDLE:
  - req is sampled each cycle.
  - Only one req high → grant that port.
  - Both high → grant the port the pointer selects. The pointer then moves to the other port.
  - On grant, latch we, N=2^size, addr and wdata. Go to ISSUE.
- ISSUE: runs for N cycles, i = 0..N-1.
  - mem_addr = (addr + i) mod 2^AW. The address wraps 0x7FFF→0x0000; unaligned addresses are legal.
  - Writes: mem_write=1, mem_wdata = wdata byte (N-1-i), so the most significant byte goes to the lowest address.
  - Reads: mem_write=0.
  - Leaving ISSUE: writes go to DONE; reads go to DRAIN.
- Read capture:
  - A RD_LAT-deep valid-flag shift register tracks issued read bytes.
  - Each byte is captured RD_LAT cycles after it was issued: rdata_acc = {rdata_acc[55:0], mem_rdata}.
  - rdata_acc is cleared at grant.
  - Capture overlaps ISSUE when N > RD_LAT.
- DRAIN: waits until all N bytes are captured, then goes to DONE.
- DONE (1 cycle):
  - mem_write=0.
  - The granted port's ack=1 and its rdata register updates. Updated on reads only; writes leave rdata unchanged.
  - rdata holds until that port's next read completes.
  - Then IDLE.
- Latency, with grant at the edge ending cycle 0:
  - Write: ack in cycle N+1.
  - Read: ack in cycle N+RD_LAT+1.
- Requester rules:
  - req, we, size, addr and wdata must be stable from assertion until ack.
  - Deasserting req mid-access does not cancel it; the access completes and acks.
  - req must drop in the cycle after ack, because it is resampled in IDLE.
- Outside ISSUE, mem_write=0 always; mem_addr and mem_wdata hold their last values.
- Ordering: a write followed by a read of the same address returns the new data. The DONE + IDLE gap covers the 2-cycle `mem` write pipeline.
- The port not granted sees ack=0 and its rdata unchanged.

Test Plan:
- Write 8 bytes: A write, size=3, addr=0x0100, wdata=0x0102030405060708 → cycles 1..8 show mem_write=1, addr 0x0100..0x0107, data 0x01..0x08; a_ack in cycle 9 only.
- Read back 8 bytes: A read, size=3, addr=0x0100 against the real `mem`/SPRAM → a_ack in cycle 12, a_rdata=0x0102030405060708. Then A read, size=0, addr=0x0103 → a_rdata=0x0000000000000004, a_ack in cycle 5.
- Simultaneous requests: a_req=b_req=1 from reset → A served first, then B. Both held continuously → grants alternate A, B, A, B; no ack is ever given to the non-granted port.
- Address wrap: B write, size=2, addr=0x7FFE, wdata=0xDEADBEEF → mem_addr sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001 with bytes DE, AD, BE, EF. B read, size=2 at 0x7FFE → b_rdata=0xDEADBEEF.
- Reset mid-operation: assert rst during ISSUE cycle 3 of an 8-byte write → mem_write=0 asynchronously, no ack, busy=0. A following 2-byte read completes normally.
- Early req drop: a_req drops in cycle 2 of a 4-byte read → the access still completes, with a_ack in cycle 8.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter that turns 1/2/4/8-byte big-endian accesses
// into byte-serial mem operations and reassembles read bytes into 64 bits.
module mem_arbiter #(
    parameter int RD_LAT = 3,
    parameter int AW     = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [1:0]    a_size,
    input  logic [AW-1:0] a_addr,
    input  logic [63:0]   a_wdata,
    output logic          a_ack,
    output logic [63:0]   a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [1:0]    b_size,
    input  logic [AW-1:0] b_addr,
    input  logic [63:0]   b_wdata,
    output logic          b_ack,
    output logic [63:0]   b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic              ptr;
    logic              gnt_b;
    logic              we_l;
    logic [2:0]        n_m1;
    logic [2:0]        idx;
    logic [2:0]        cap_cnt;
    logic [63:0]       wdata_l;
    logic [55:0]       acc;
    logic [RD_LAT-1:0] vld;

    logic              grant;
    logic              grant_b;
    logic              last_issue;
    logic              cap;
    logic              last_cap;
    logic [63:0]       acc_n;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic [AW-1:0]     sel_addr;
    logic [63:0]       sel_wdata;
    logic [2:0]        sel_nm1;

    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_size  = grant_b ? b_size  : a_size;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    // byte count minus one: 0,1,3,7
    assign sel_nm1   = {&sel_size, sel_size[1], |sel_size};

    assign last_issue = (idx == n_m1);
    assign cap        = vld[RD_LAT-1];
    assign last_cap   = cap && (cap_cnt == n_m1);
    assign acc_n      = {acc, mem_rdata};

    assign a_ack = (state == DONE) && !gnt_b;
    assign b_ack = (state == DONE) && gnt_b;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        grant_b = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    grant   = 1'b1;
                    grant_b = b_req && (!a_req || ptr);
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) state_n = we_l ? DONE : DRAIN;
            end
            DRAIN: begin
                if (last_cap) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            gnt_b     <= 1'b0;
            we_l      <= 1'b0;
            n_m1      <= 3'd0;
            idx       <= 3'd0;
            cap_cnt   <= 3'd0;
            wdata_l   <= 64'd0;
            acc       <= 56'd0;
            vld       <= '0;
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_wdata <= 8'd0;
            a_rdata   <= 64'd0;
            b_rdata   <= 64'd0;
        end else begin
            // one flag per read byte, emerging when its data is on mem_rdata
            vld <= {vld[RD_LAT-2:0], (state == ISSUE) && !we_l};
            if (cap) begin
                acc     <= acc_n[55:0];
                cap_cnt <= cap_cnt + 3'd1;
            end
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        if (a_req && b_req) ptr <= ~ptr;
                        gnt_b     <= grant_b;
                        we_l      <= sel_we;
                        n_m1      <= sel_nm1;
                        wdata_l   <= sel_wdata;
                        idx       <= 3'd0;
                        cap_cnt   <= 3'd0;
                        acc       <= 56'd0;
                        mem_addr  <= sel_addr;
                        mem_write <= sel_we;
                        if (sel_we) mem_wdata <= sel_wdata[{sel_nm1, 3'b000} +: 8];
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        mem_write <= 1'b0;
                    end else begin
                        idx      <= idx + 3'd1;
                        mem_addr <= mem_addr + AW'(1);
                        if (we_l) mem_wdata <= wdata_l[{n_m1 - idx - 3'd1, 3'b000} +: 8];
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        if (gnt_b) b_rdata <= acc_n;
                        else       a_rdata <= acc_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter with a byte SRAM model
// and a flat reference memory for expected read data.
module tb_mem_arbiter;

    localparam int AW     = 15;
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [1:0]    a_size = 2'd0;
    logic [AW-1:0] a_addr = '0;
    logic [63:0]   a_wdata = 64'd0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [1:0]    b_size = 2'd0;
    logic [AW-1:0] b_addr = '0;
    logic [63:0]   b_wdata = 64'd0;
    logic          a_ack, b_ack, mem_write, busy;
    logic [63:0]   a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    int ncmp = 0;
    int nfail = 0;

    bit [7:0] sram [0:32767];
    bit [7:0] refm [0:32767];
    bit [7:0] p0, p1, p2;

    mem_arbiter #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // byte SRAM with a three-stage read pipeline
    always_ff @(posedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_wdata;
        p0 <= sram[mem_addr];
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata = p2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_rd(input logic [AW-1:0] ad, input int n);
        logic [63:0] v;
        logic [AW-1:0] x;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            x = ad + AW'(i);
            v = {v[55:0], refm[x]};
        end
        return v;
    endfunction

    task automatic ref_wr(input logic [AW-1:0] ad, input int n, input logic [63:0] wd);
        logic [AW-1:0] x;
        for (int i = 0; i < n; i++) begin
            x = ad + AW'(i);
            refm[x] = 8'(wd >> (8 * (n - 1 - i)));
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [1:0] sz,
                            input logic [AW-1:0] ad, input logic [63:0] wd);
        if (!p) begin
            a_req = rq; a_we = we; a_size = sz; a_addr = ad; a_wdata = wd;
        end else begin
            b_req = rq; b_we = we; b_size = sz; b_addr = ad; b_wdata = wd;
        end
    endtask

    task automatic access(input bit p, input bit we, input logic [1:0] sz,
                          input logic [AW-1:0] ad, input logic [63:0] wd, input int drop_at);
        int n, lat, cyc;
        bit got;
        logic [63:0] other_rd, exp;
        logic [AW-1:0] ea;
        n = 1 << sz;
        lat = we ? n + 1 : n + RD_LAT + 1;
        exp = ref_rd(ad, n);
        @(posedge clk); #1;
        other_rd = p ? a_rdata : b_rdata;
        set_port(p, 1'b1, we, sz, ad, wd);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == drop_at) begin
                if (!p) a_req = 1'b0; else b_req = 1'b0;
            end
            if (cyc <= n) begin
                ea = ad + AW'(cyc - 1);
                chk("mem_addr", mem_addr, ea);
                chk("mem_write", mem_write, we);
                if (we) chk("mem_wdata", mem_wdata, 8'(wd >> (8 * (n - cyc))));
            end
            chk("other_ack", p ? a_ack : b_ack, 0);
            got = p ? b_ack : a_ack;
        end
        chk("ack_cycle", cyc, lat);
        if (got) begin
            if (!we) chk("rdata", p ? b_rdata : a_rdata, exp);
            chk("other_rdata", p ? a_rdata : b_rdata, other_rd);
            chk("done_mem_write", mem_write, 0);
            if (we) ref_wr(ad, n, wd);
        end
        set_port(p, 1'b0, we, sz, ad, wd);
        @(posedge clk); #1;
        chk("ack_pulse", p ? b_ack : a_ack, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int acks, cyc;
        int order [4];

        // both ports request straight out of reset
        set_port(1'b0, 1'b1, 1'b1, 2'd0, 15'h0300, 64'h55);
        set_port(1'b1, 1'b1, 1'b1, 2'd0, 15'h0301, 64'h66);
        #1;
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        acks = 0;
        cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            chk("dual_ack", a_ack & b_ack, 0);
            if (a_ack || b_ack) begin
                order[acks] = b_ack ? 1 : 0;
                acks++;
                if (acks == 4) begin
                    a_req = 1'b0;
                    b_req = 1'b0;
                end
            end
        end
        chk("rr_acks", acks, 4);
        for (int k = 0; k < acks; k++) chk("rr_order", order[k], k % 2);
        ref_wr(15'h0300, 1, 64'h55);
        ref_wr(15'h0301, 1, 64'h66);

        // 8-byte write then readbacks
        access(1'b0, 1'b1, 2'd3, 15'h0100, 64'h0102030405060708, -1);
        access(1'b0, 1'b0, 2'd3, 15'h0100, 64'd0, -1);
        chk("rd8_value", a_rdata, 64'h0102030405060708);
        access(1'b0, 1'b0, 2'd0, 15'h0103, 64'd0, -1);
        chk("rd1_value", a_rdata, 64'h04);
        access(1'b1, 1'b0, 2'd0, 15'h0300, 64'd0, -1);
        chk("rr_data", b_rdata, 64'h55);

        // address wrap
        access(1'b1, 1'b1, 2'd2, 15'h7FFE, 64'hDEADBEEF, -1);
        access(1'b1, 1'b0, 2'd2, 15'h7FFE, 64'd0, -1);
        chk("wrap_value", b_rdata, 64'hDEADBEEF);

        // early request drop on a 4-byte read
        access(1'b0, 1'b0, 2'd2, 15'h0104, 64'd0, 2);
        chk("drop_value", a_rdata, 64'h05060708);

        // reset in ISSUE cycle 3 of an 8-byte write
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 2'd3, 15'h0200, 64'h1112131415161718);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_write", mem_write, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_write", mem_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", a_ack, 0);
        chk("midrst_rdata", a_rdata, 0);
        a_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        refm[15'h0200] = 8'h11;
        refm[15'h0201] = 8'h12;
        access(1'b0, 1'b0, 2'd1, 15'h0200, 64'd0, -1);
        chk("post_rst_value", a_rdata, 64'h1112);

        // randomized traffic around the wrap point
        for (int k = 0; k < 40; k++) begin
            bit p, we;
            logic [1:0] sz;
            logic [AW-1:0] ad;
            logic [63:0] wd, mask;
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            ad = AW'(32'h7FF8 + $urandom_range(0, 24));
            mask = (sz == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << sz)) - 64'd1);
            wd = {$urandom, $urandom} & mask;
            access(p, we, sz, ad, wd, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
